w_burst_rr_arbiter: RTL

- Round-robin arbiter that shares one memory write-beat port between NUM_REQ W-beat FIFOs.
- A grant is held for a whole burst, from the first beat to the beat with last set, so beats of different bursts never interleave.
- Sits between the per-port W FIFOs (pop interface) and the memory request path in the axi_to_mem datapath.

---
 rtl/w_burst_rr_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/w_burst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// w_burst_rr_arbiter
//
// Round-robin arbiter sharing one memory write-beat port between NUM_REQ
// W-beat FIFOs. A grant is held from the first beat of a burst up to and
// including the beat carrying last. Beats of different bursts therefore never
// interleave. Forwarding from the granted FIFO head to the memory port is
// combinational. Grant, grant index and busy come from registered state only.
//
// Optional feature (macro W_BURST_ARB_TIMEOUT_EN):
//   When defined, a granted requester whose FIFO stays empty for
//   TIMEOUT_CYCLES consecutive BURST cycles loses its grant. timeout_o
//   pulses in the release cycle. When undefined, the grant is held until the
//   last beat is accepted and timeout_o is tied low.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous abort back to idle (pointer cleared)
//   req_valid_i  per-FIFO not-empty
//   req_data_i   per-FIFO head beat, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   per-FIFO head beat is last of its burst
//   req_pop_o    per-FIFO pop strobe
//   mem_valid_o  beat valid toward memory
//   mem_data_o   forwarded beat (0 when idle)
//   mem_last_o   forwarded last flag
//   mem_ready_i  memory accepts beat
//   grant_o      one-hot current grant (0 when idle)
//   grant_id_o   index of the current/most recent grant
//   busy_o       BURST state
//   timeout_o    one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module w_burst_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 41,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0]               req_last_i,
  output logic [NUM_REQ-1:0]               req_pop_o,
  output logic                             mem_valid_o,
  output logic [DATA_WIDTH-1:0]            mem_data_o,
  output logic                             mem_last_o,
  input  logic                             mem_ready_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic [ID_WIDTH-1:0]              grant_id_o,
  output logic                             busy_o,
  output logic                             timeout_o
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("w_burst_rr_arbiter: NUM_REQ must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("w_burst_rr_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [NUM_REQ-1:0]    r_grant;

  logic                  w_busy;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_accept;
  logic                  w_burst_done;
  logic                  w_timeout;
  logic [ID_WIDTH-1:0]   w_next_ptr;
  logic                  w_arb_hit;
  logic [ID_WIDTH-1:0]   w_arb_idx;

  assign w_busy       = (r_state == S_BURST);
  assign w_g_valid    = req_valid_i[r_grant_id];
  assign w_g_last     = req_last_i[r_grant_id];
  assign w_g_data     = req_data_i[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept     = w_busy & w_g_valid & mem_ready_i;
  assign w_burst_done = w_accept & w_g_last;

  // Pointer moves one past the requester just served, wrapping explicitly so
  // non-power-of-two NUM_REQ works.
  assign w_next_ptr = (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : r_grant_id + 1'b1;

  // Round-robin pick: first valid index scanning r_rr_ptr upward with wrap.
  // The loop walks from the farthest offset down so the nearest one wins.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_arb_hit = 1'b0;
    w_arb_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid_i[idx]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = ID_WIDTH'(idx);
      end
    end
  end

`ifdef W_BURST_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [STALL_W-1:0] r_stall_cnt;

  // Release in the cycle the counter sits at its limit with the head still
  // empty; nothing is popped because the granted FIFO has no beat.
  assign w_timeout = w_busy & ~w_g_valid &
                     (r_stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (flush_i) begin
      r_stall_cnt <= '0;
    end else if (!w_busy || w_g_valid || w_timeout) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Arbitration FSM. flush_i outranks every state update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_grant    <= '0;
    end else if (flush_i) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_grant    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_arb_hit) begin
            r_state    <= S_BURST;
            r_grant_id <= w_arb_idx;
            r_grant    <= NUM_REQ'(1) << w_arb_idx;
          end
        end
        S_BURST: begin
          if (w_burst_done || w_timeout) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
            r_grant  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_pop_o = '0;
    if (w_busy) begin
      req_pop_o[r_grant_id] = w_g_valid & mem_ready_i;
    end
  end

  assign mem_valid_o = w_busy & w_g_valid;
  assign mem_data_o  = w_busy ? w_g_data : '0;
  assign mem_last_o  = w_busy & w_g_last;
  assign grant_o     = r_grant;
  assign grant_id_o  = r_grant_id;
  assign busy_o      = w_busy;
  assign timeout_o   = w_timeout;

endmodule
